// File: rtl/aes_sub_bytes_pipe.sv
// Two-stage pipelined AES SubBytes: S1 registers the raw word, S2 registers
// the per-lane forward or inverse S-box result, with valid/ready on both sides.
module aes_sub_bytes_pipe #(
    parameter int LANES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv
);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // The inverse table is the permutation inverse of the forward one,
    // folded at elaboration so only constant ROMs reach the netlist.
    function automatic logic [2047:0] build_inv();
        logic [2047:0] t;
        logic [7:0]    s;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            s = SBOX_FWD[{~8'(i), 3'b000} +: 8];
            t[{~s, 3'b000} +: 8] = 8'(i);
        end
        return t;
    endfunction

    localparam logic [2047:0] SBOX_INV = build_inv();

    function automatic logic [7:0] lookup(input logic [7:0] b, input logic inv);
        return inv ? SBOX_INV[{~b, 3'b000} +: 8] : SBOX_FWD[{~b, 3'b000} +: 8];
    endfunction

    logic               s1_valid;
    logic [8*LANES-1:0] s1_data;
    logic               s1_inv;
    logic [8*LANES-1:0] sub_data;
    logic               adv;
    logic               accept;

    assign adv      = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sub_data = '0;
        for (int i = 0; i < LANES; i++) begin
            sub_data[8*i +: 8] = lookup(s1_data[8*i +: 8], s1_inv);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; S2 may load from S1 in the same edge S1 reloads.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_inv    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_inv   <= 1'b0;
        end else begin
            if (accept) begin
                s1_data <= in_data;
                s1_inv  <= in_inv;
            end
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (adv) begin
                s1_valid <= 1'b0;
            end
            if (adv) begin
                out_data  <= sub_data;
                out_inv   <= s1_inv;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
